// File: rtl/bsg_encode_multi_hot_serial.sv
// Serial multi-hot encoder: captures a request vector and emits the index of
// every set bit, one per yumi handshake, in lo->hi or hi->lo order.
module bsg_encode_multi_hot_serial #(
  parameter int width_p    = 64,
  parameter bit lo_to_hi_p = 1'b1,
  localparam int addr_width_lp  = (width_p > 1) ? $clog2(width_p) : 1,
  localparam int count_width_lp = $clog2(width_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [addr_width_lp-1:0]  addr_o,
  output logic                      last_o,
  output logic [count_width_lp-1:0] count_o,
  input  logic                      yumi_i
);

  logic [width_p-1:0]        pending_r, pending_n, sel_oh;
  logic [count_width_lp-1:0] count_r, count_n, popcnt;
  logic [addr_width_lp-1:0]  sel_addr;
  logic                      accept, consume;

  // Priority select: the loop runs so that the preferred bit is written last.
  always_comb begin
    sel_addr = '0;
    sel_oh   = '0;
    if (lo_to_hi_p) begin
      for (int k = width_p - 1; k >= 0; k--) begin
        if (pending_r[k]) begin
          sel_addr  = addr_width_lp'(k);
          sel_oh    = '0;
          sel_oh[k] = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < width_p; k++) begin
        if (pending_r[k]) begin
          sel_addr  = addr_width_lp'(k);
          sel_oh    = '0;
          sel_oh[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    popcnt = '0;
    for (int k = 0; k < width_p; k++)
      popcnt = popcnt + count_width_lp'(i[k]);
  end

  assign ready_o = (pending_r == '0);
  assign v_o     = |pending_r;
  assign addr_o  = sel_addr;
  assign last_o  = v_o & (count_r == count_width_lp'(1));
  assign count_o = count_r;

  // ready_o and v_o are mutually exclusive, so at most one of these acts.
  assign accept  = v_i & ready_o;
  assign consume = yumi_i & v_o;

  always_comb begin
    pending_n = pending_r;
    count_n   = count_r;
    if (accept) begin
      pending_n = i;
      count_n   = popcnt;
    end else if (consume) begin
      pending_n = pending_r & ~sel_oh;
      count_n   = count_r - count_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_r <= '0;
      count_r   <= '0;
    end else begin
      pending_r <= pending_n;
      count_r   <= count_n;
    end
  end

`ifndef SYNTHESIS
  illegal_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $warning("bsg_encode_multi_hot_serial: yumi_i while v_o low is ignored");
`endif

endmodule

// File: tb/tb_bsg_encode_multi_hot_serial.sv
// Bench for bsg_encode_multi_hot_serial: ascending, descending and width-1
// instances checked against a queue-of-indices reference model.
module tb_bsg_encode_multi_hot_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, v_in, yumi;
  logic [63:0] vec;
  logic        rdy_a, v_a, last_a, rdy_d, v_d, last_d;
  logic [5:0]  addr_a, addr_d;
  logic [6:0]  cnt_a, cnt_d;
  logic        v1_in, yumi1, i1, rdy1, v1, addr1, last1, cnt1;

  bsg_encode_multi_hot_serial #(.width_p(64), .lo_to_hi_p(1'b1)) dut_asc (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in), .i(vec), .ready_o(rdy_a), .v_o(v_a),
    .addr_o(addr_a), .last_o(last_a), .count_o(cnt_a), .yumi_i(yumi));

  bsg_encode_multi_hot_serial #(.width_p(64), .lo_to_hi_p(1'b0)) dut_desc (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in), .i(vec), .ready_o(rdy_d), .v_o(v_d),
    .addr_o(addr_d), .last_o(last_d), .count_o(cnt_d), .yumi_i(yumi));

  bsg_encode_multi_hot_serial #(.width_p(1)) dut_w1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v1_in), .i(i1), .ready_o(rdy1), .v_o(v1),
    .addr_o(addr1), .last_o(last1), .count_o(cnt1), .yumi_i(yumi1));

  logic [15:0] obs_a, obs_d;
  logic [4:0]  obs1;
  assign obs_a = {rdy_a, v_a, addr_a, last_a, cnt_a};
  assign obs_d = {rdy_d, v_d, addr_d, last_d, cnt_d};
  assign obs1  = {rdy1, v1, addr1, last1, cnt1};

  int checks = 0, errors = 0;
  int qa[$], qd[$];   // pending indices in emission order
  int q1;             // width-1 model: number of pending bits

  function automatic logic [15:0] exp_of(input int head, input int n);
    logic [5:0] a;
    a = (n > 0) ? 6'(head) : 6'd0;
    return {(n == 0), (n > 0), a, (n == 1), 7'(n)};
  endfunction

  function automatic logic [15:0] exp_a();
    return exp_of((qa.size() > 0) ? qa[0] : 0, qa.size());
  endfunction

  function automatic logic [15:0] exp_d();
    return exp_of((qd.size() > 0) ? qd[0] : 0, qd.size());
  endfunction

  task automatic load_model(input logic [63:0] v);
    qa.delete();
    qd.delete();
    for (int k = 0; k < 64; k++)
      if (v[k]) begin
        qa.push_back(k);
        qd.push_front(k);
      end
  endtask

  // Advance the model by the upcoming edge, then move to 1 time unit after it.
  task automatic tick();
    if (rst_n) begin
      if (qa.size() == 0) begin
        if (v_in) load_model(vec);
      end else if (yumi) begin
        qa.delete(0);
        qd.delete(0);
      end
      if (q1 == 0) begin
        if (v1_in) q1 = int'(i1);
      end else if (yumi1) q1 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_a !== 16'h8000) begin
      errors++;
      $display("FAIL reset_a got %h want %h", obs_a, 16'h8000);
    end
    checks++;
    if (obs1 !== 5'b10000) begin
      errors++;
      $display("FAIL reset_w1 got %b want %b", obs1, 5'b10000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vec = 64'h7F; v_in = 1'b1; tick(); v_in = 1'b0;
    yumi = 1'b1; tick(); tick(); yumi = 1'b0;
    checks++;
    if (cnt_a !== 7'd5 || obs_a !== exp_a()) begin
      errors++;
      $display("FAIL pre_reset_count got %h want %h", obs_a, exp_a());
    end
    rst_n = 1'b0;
    #2;
    qa.delete(); qd.delete(); q1 = 0;
    checks++;
    if (obs_a !== 16'h8000 || obs_d !== 16'h8000) begin
      errors++;
      $display("FAIL mid_reset got %h/%h want 8000", obs_a, obs_d);
    end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== 16'h8000) begin
      errors++;
      $display("FAIL held_reset got %h want 8000", obs_a);
    end
    rst_n = 1'b1;
    vec = 64'h1; v_in = 1'b1; tick(); v_in = 1'b0;
    checks++;
    if (obs_a !== exp_a() || addr_a !== 6'd0 || last_a !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got %h want %h", obs_a, exp_a());
    end
    yumi = 1'b1; tick(); yumi = 1'b0;
    checks++;
    if (obs_a !== 16'h8000) begin
      errors++;
      $display("FAIL after_reset_idle got %h want 8000", obs_a);
    end
  endtask

  task automatic test_drain();
    int asc[3];
    int dsc[3];
    asc = '{0, 2, 63};
    dsc = '{63, 2, 0};
    vec = 64'h8000_0000_0000_0005; v_in = 1'b1; tick(); v_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_a !== exp_a() || addr_a !== 6'(asc[c])) begin
        errors++;
        $display("FAIL drain_asc c%0d got %h want %h addr %0d", c, obs_a, exp_a(), asc[c]);
      end
      checks++;
      if (obs_d !== exp_d() || addr_d !== 6'(dsc[c])) begin
        errors++;
        $display("FAIL drain_desc c%0d got %h want %h addr %0d", c, obs_d, exp_d(), dsc[c]);
      end
      yumi = 1'b1; tick();
    end
    yumi = 1'b0;
    checks++;
    if (rdy_a !== 1'b1 || rdy_d !== 1'b1 || v_a !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got rdy %b/%b v %b want 1/1 0", rdy_a, rdy_d, v_a);
    end
  endtask

  task automatic test_backpressure();
    vec = 64'hF0; v_in = 1'b1; tick(); v_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs_a !== exp_a() || addr_a !== 6'(4 + c / 3)) begin
        errors++;
        $display("FAIL backpressure_asc c%0d got %h want %h", c, obs_a, exp_a());
      end
      checks++;
      if (obs_d !== exp_d()) begin
        errors++;
        $display("FAIL backpressure_desc c%0d got %h want %h", c, obs_d, exp_d());
      end
      yumi = (c % 3 == 2);
      v_in = (c % 2 == 1);
      vec  = {$urandom, $urandom};
      tick();
    end
    yumi = 1'b0; v_in = 1'b0;
    checks++;
    if (obs_a !== 16'h8000) begin
      errors++;
      $display("FAIL backpressure_idle got %h want 8000", obs_a);
    end
  endtask

  task automatic test_edges();
    vec = 64'h0; v_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (v_a !== 1'b0 || rdy_a !== 1'b1 || obs_d !== 16'h8000) begin
        errors++;
        $display("FAIL zero_vec c%0d got v %b rdy %b want 0 1", c, v_a, rdy_a);
      end
    end
    v_in = 1'b0;
    vec = '1; v_in = 1'b1; tick(); v_in = 1'b0;
    checks++;
    if (cnt_a !== 7'd64 || cnt_d !== 7'd64) begin
      errors++;
      $display("FAIL ones_count got %0d/%0d want 64", cnt_a, cnt_d);
    end
    yumi = 1'b1;
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (obs_a !== exp_a() || obs_d !== exp_d()) begin
        errors++;
        $display("FAIL ones_drain c%0d got %h/%h want %h/%h", c, obs_a, obs_d, exp_a(), exp_d());
      end
      if (c == 63) yumi = 1'b1;
      tick();
    end
    yumi = 1'b0;
    checks++;
    if (obs_a !== 16'h8000 || obs_d !== 16'h8000) begin
      errors++;
      $display("FAIL ones_idle got %h/%h want 8000", obs_a, obs_d);
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 25; t++) begin
      vec = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      v_in = 1'b1; tick(); v_in = 1'b0;
      n = 0;
      while (qa.size() > 0 && n < 300) begin
        checks++;
        if (obs_a !== exp_a() || obs_d !== exp_d()) begin
          errors++;
          $display("FAIL random t%0d n%0d got %h/%h want %h/%h", t, n, obs_a, obs_d, exp_a(), exp_d());
        end
        yumi = ($urandom_range(2, 0) != 0);
        v_in = ($urandom_range(3, 0) == 0);
        vec  = {$urandom, $urandom};
        tick();
        n++;
      end
      yumi = 1'b0; v_in = 1'b0;
      checks++;
      if (n >= 300 || obs_a !== 16'h8000) begin
        errors++;
        $display("FAIL random_end t%0d got %h want 8000 cycles %0d", t, obs_a, n);
      end
    end
  endtask

  task automatic test_illegal_yumi();
    yumi = 1'b1; tick(); yumi = 1'b0;
    checks++;
    if (obs_a !== 16'h8000 || obs_d !== 16'h8000) begin
      errors++;
      $display("FAIL illegal_yumi got %h/%h want 8000", obs_a, obs_d);
    end
  endtask

  task automatic test_width1();
    i1 = 1'b1; v1_in = 1'b1; tick(); v1_in = 1'b0;
    checks++;
    if (obs1 !== 5'b01011) begin
      errors++;
      $display("FAIL w1_busy got %b want %b", obs1, 5'b01011);
    end
    tick();
    checks++;
    if (obs1 !== 5'b01011) begin
      errors++;
      $display("FAIL w1_hold got %b want %b", obs1, 5'b01011);
    end
    yumi1 = 1'b1; tick(); yumi1 = 1'b0;
    checks++;
    if (obs1 !== 5'b10000 || q1 != 0) begin
      errors++;
      $display("FAIL w1_idle got %b want %b", obs1, 5'b10000);
    end
    i1 = 1'b0; v1_in = 1'b1; tick(); v1_in = 1'b0;
    checks++;
    if (obs1 !== 5'b10000) begin
      errors++;
      $display("FAIL w1_zero got %b want %b", obs1, 5'b10000);
    end
  endtask

  initial begin
    rst_n = 1'b1; v_in = 1'b0; yumi = 1'b0; vec = '0;
    v1_in = 1'b0; yumi1 = 1'b0; i1 = 1'b0; q1 = 0;
    #3 rst_n = 1'b0;
    #9;
    test_reset();
    test_drain();
    test_backpressure();
    test_edges();
    test_random();
    test_illegal_yumi();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
